// File: rtl/bsg_dff_pipe_vr_pkg.sv
// Shared types for the valid/ready register pipe: transfer classification
// used by the occupancy counter.
package bsg_dff_pipe_vr_pkg;

  // Bit 1 = output transfer, bit 0 = input transfer.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_IN   = 2'b01,
    XFER_OUT  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

// File: rtl/bsg_dff_vr_stage.sv
// Single valid+data register stage. Data only loads on a valid beat so
// bubbles passing through leave the data register quiet.
module bsg_dff_vr_stage #(
  parameter int                 width_p     = 16,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= reset_val_p;
    end else if (en_i) begin
      v_o <= v_i;
      if (v_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_dff_pipe_vr.sv
// Chain of els_p valid/ready register stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module bsg_dff_pipe_vr
  import bsg_dff_pipe_vr_pkg::*;
#(
  parameter int                 width_p     = 16,
  parameter int                 els_p       = 2,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         v_o,
  input  logic                         ready_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int count_width_lp = $clog2(els_p+1);

  logic [els_p-1:0]          valid_r;
  logic [els_p-1:0]          adv;
  logic [width_p-1:0]        data_r [els_p];
  logic [count_width_lp-1:0] count_r;
  logic                      in_xfer;
  logic                      out_xfer;
  xfer_e                     xfer;

  // A stage may advance unless it and every stage after it are full while
  // the consumer stalls; written as a suffix-AND so no bit feeds another.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    adv   = '0;
    for (int k = els_p-1; k >= 0; k--) begin
      all_v  = all_v & valid_r[k];
      adv[k] = ready_i | ~all_v;
    end
  end

  for (genvar k = 0; k < els_p; k++) begin : g_stage
    logic               up_v;
    logic [width_p-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_v    = v_i;
      assign up_data = data_i;
    end else begin : g_body
      assign up_v    = valid_r[k-1];
      assign up_data = data_r[k-1];
    end

    // Flush forces every stage to load an invalid beat, leaving data intact.
    bsg_dff_vr_stage #(
      .width_p    (width_p),
      .reset_val_p(reset_val_p)
    ) stage (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (adv[k] | flush_i),
      .v_i      (up_v & ~flush_i),
      .data_i   (up_data),
      .v_o      (valid_r[k]),
      .data_o   (data_r[k])
    );
  end

  assign ready_o  = adv[0] & ~flush_i & reset_n_i;
  assign v_o      = valid_r[els_p-1];
  assign data_o   = data_r[els_p-1];
  assign in_xfer  = v_i & ready_o;
  assign out_xfer = v_o & ready_i;
  assign xfer     = xfer_e'({out_xfer, in_xfer});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (flush_i) begin
      count_r <= '0;
    end else begin
      case (xfer)
        XFER_IN:  count_r <= count_r + count_width_lp'(1);
        XFER_OUT: count_r <= count_r - count_width_lp'(1);
        default:  count_r <= count_r;
      endcase
    end
  end

  assign count_o = count_r;

  a_count_bound : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_r <= count_width_lp'(els_p));

  a_data_stable : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_o & ~ready_i) |=> $stable(data_o));

endmodule
